// File: rtl/inv_permutation_func_pkg.sv
// Shared definitions for the inverse slice permutation block.
//   SLICE_W    : bits per slice word (5x5 lane grid)
//   NUM_SLICES : slices processed per pass
//   CNT_W      : slice counter width, one bit wider than the address to hold the carry
//   state_t    : controller state encoding
//   inv_src_bit: elaboration-time source bit index for the inverse mapping
package inv_permutation_func_pkg;

    localparam int SLICE_W    = 25;
    localparam int NUM_SLICES = 64;
    localparam int CNT_W      = 7;
    localparam int GRID       = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Output bit 5*y+x takes slice bit 5*((2x+3y) mod 5)+y. Only ever evaluated
    // with constant arguments, so it resolves to fixed wiring.
    function automatic int inv_src_bit(input int x, input int y);
        return GRID * ((2 * x + 3 * y) % GRID) + y;
    endfunction

endpackage

// File: rtl/inv_permute_controller.sv
// Sequencing FSM for the inverse permutation pass.
// Walks IDLE -> INIT -> (READ -> WRITE) x NUM_SLICES -> DONE -> IDLE.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : pass request, honoured only in IDLE
//   cnt_last_i      : counter currently addresses the last slice
//   read_enable_o   : source read strobe (READ)
//   write_enable_o  : result write strobe (WRITE)
//   cnt_en_o        : advance the slice counter (WRITE)
//   cnt_clr_o       : clear counter and slice register (INIT)
//   reg_en_o        : load the slice register from the source (READ)
//   done_o          : end-of-pass pulse (DONE)
module inv_permute_controller
    import inv_permutation_func_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic cnt_last_i,
    output logic read_enable_o,
    output logic write_enable_o,
    output logic cnt_en_o,
    output logic cnt_clr_o,
    output logic reg_en_o,
    output logic done_o
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_INIT;
            ST_INIT:  state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = cnt_last_i ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: all strobes drop the instant reset forces IDLE.
    always_comb begin
        read_enable_o  = 1'b0;
        write_enable_o = 1'b0;
        cnt_en_o       = 1'b0;
        cnt_clr_o      = 1'b0;
        reg_en_o       = 1'b0;
        done_o         = 1'b0;
        case (state_q)
            ST_INIT:  cnt_clr_o = 1'b1;
            ST_READ: begin
                read_enable_o = 1'b1;
                reg_en_o      = 1'b1;
            end
            ST_WRITE: begin
                write_enable_o = 1'b1;
                cnt_en_o       = 1'b1;
            end
            ST_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/inv_permutation_func.sv
// Inverse slice permutation: reads NUM_SLICES slice words from a source
// buffer, undoes the encoder's forward lane permutation on each and writes
// the result back out, one slice per READ/WRITE pair.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : pass request (level, sampled in IDLE)
//   line_in      : source slice at address cnt_value, valid during read_enable
//   read_enable  : source read strobe
//   cnt_value    : slice address; reads NUM_SLICES after the final write
//   write_enable : one-cycle strobe per slice qualifying write_value
//   write_value  : inverse-permuted slice
//   done         : one-cycle end-of-pass pulse
module inv_permutation_func
    import inv_permutation_func_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SLICE_W-1:0] line_in,
    output logic               read_enable,
    output logic [CNT_W-1:0]   cnt_value,
    output logic               write_enable,
    output logic [SLICE_W-1:0] write_value,
    output logic               done
);

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [SLICE_W-1:0] slice_q;
    logic [SLICE_W-1:0] slice_d;

    logic cnt_en;
    logic cnt_clr;
    logic reg_en;
    logic cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(NUM_SLICES - 1));

    inv_permute_controller u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .cnt_last_i     (cnt_last),
        .read_enable_o  (read_enable),
        .write_enable_o (write_enable),
        .cnt_en_o       (cnt_en),
        .cnt_clr_o      (cnt_clr),
        .reg_en_o       (reg_en),
        .done_o         (done)
    );

    // The carry bit lets the counter rest at NUM_SLICES after the last
    // write instead of wrapping; the next INIT brings it back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        slice_d = slice_q;
        if (cnt_clr) begin
            slice_d = '0;
        end else if (reg_en) begin
            slice_d = line_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            slice_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slice_q <= slice_d;
        end
    end

    assign cnt_value = cnt_q;

    // Fixed bit routing from the captured slice; write_value only moves when
    // slice_q does, so it holds between writes.
    for (genvar gy = 0; gy < GRID; gy++) begin : g_row
        for (genvar gx = 0; gx < GRID; gx++) begin : g_col
            assign write_value[GRID * gy + gx] = slice_q[inv_src_bit(gx, gy)];
        end
    end

endmodule

// File: tb/tb_inv_permutation_func.sv
module tb_inv_permutation_func;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [24:0] line_in;
    logic        read_enable;
    logic [6:0]  cnt_value;
    logic        write_enable;
    logic [24:0] write_value;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [24:0] src_mem [64];
    logic [24:0] exp_val_q [$];
    logic [6:0]  exp_cnt_q [$];
    logic [24:0] mon_ev;
    logic [6:0]  mon_ec;

    always #5 clk = ~clk;

    // Source buffer answers combinationally at the current address.
    assign line_in = src_mem[cnt_value[5:0]];

    inv_permutation_func dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .line_in      (line_in),
        .read_enable  (read_enable),
        .cnt_value    (cnt_value),
        .write_enable (write_enable),
        .write_value  (write_value),
        .done         (done)
    );

    // Encoder-side forward permutation: bit 5y+x of the original lands at
    // bit 5*((2x+3y) mod 5)+y of the stored slice.
    function automatic logic [24:0] fwd_permute(input logic [24:0] v);
        logic [24:0] e;
        e = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                e[5 * ((2 * x + 3 * y) % 5) + y] = v[5 * y + x];
        return e;
    endfunction

    // Scoreboard: every write pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            checks++;
            if (exp_val_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected write cnt_value=%0d value=%h", cnt_value, write_value);
            end else begin
                mon_ev = exp_val_q.pop_front();
                mon_ec = exp_cnt_q.pop_front();
                if (write_value !== mon_ev || cnt_value !== mon_ec) begin
                    errors++;
                    $display("FAIL sb_write: got cnt=%0d val=%h, expected cnt=%0d val=%h",
                             cnt_value, write_value, mon_ec, mon_ev);
                end
            end
        end
    end

    task automatic flush_sb();
        exp_val_q.delete();
        exp_cnt_q.delete();
    endtask

    task automatic load_random();
        logic [24:0] orig;
        for (int k = 0; k < 64; k++) begin
            orig = 25'($urandom);
            src_mem[k] = fwd_permute(orig);
            exp_val_q.push_back(orig);
            exp_cnt_q.push_back(7'(k));
        end
    endtask

    // Runs one pass from a one-cycle start; cycle 1 is the cycle start is high.
    task automatic run_pass(input bit toggle, output int done_cyc, output int nwr,
                            output int maxrun, output logic [6:0] done_cnt,
                            output logic done_after);
        int run;
        run = 0; done_cyc = 0; nwr = 0; maxrun = 0; done_cnt = '0;
        @(posedge clk); #1 start = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (write_enable) begin
                nwr++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (done) begin
                done_cyc = n;
                done_cnt = cnt_value;
                break;
            end
            @(posedge clk); #1;
            start = (toggle && cnt_value < 7'd60) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (read_enable !== 1'b0) begin errors++; $display("FAIL rst_read_enable: got %b want 0", read_enable); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rst_write_enable: got %b want 0", write_enable); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (cnt_value !== 7'd0) begin errors++; $display("FAIL rst_cnt_value: got %0d want 0", cnt_value); end
        checks++; if (write_value !== 25'd0) begin errors++; $display("FAIL rst_write_value: got %h want 0", write_value); end
        rst = 1'b0;
    endtask

    task automatic test_single_bit();
        int dc, nw, mr;
        logic [6:0] dcv;
        logic da;
        flush_sb();
        for (int k = 0; k < 64; k++) src_mem[k] = '0;
        src_mem[0] = 25'h0000400;
        src_mem[1] = 25'h0010000;
        src_mem[2] = 25'h0000001;
        exp_val_q.push_back(25'h0000002); exp_cnt_q.push_back(7'd0);
        exp_val_q.push_back(25'h0000020); exp_cnt_q.push_back(7'd1);
        exp_val_q.push_back(25'h0000001); exp_cnt_q.push_back(7'd2);
        for (int k = 3; k < 64; k++) begin
            exp_val_q.push_back(25'h0); exp_cnt_q.push_back(7'(k));
        end
        run_pass(1'b0, dc, nw, mr, dcv, da);
        checks++; if (nw != 64) begin errors++; $display("FAIL single_bit_writes: got %0d want 64", nw); end
        checks++; if (exp_val_q.size() != 0) begin errors++; $display("FAIL single_bit_sb_left: got %0d want 0", exp_val_q.size()); end
    endtask

    task automatic test_round_trip();
        int dc, nw, mr;
        logic [6:0] dcv;
        logic da;
        flush_sb();
        load_random();
        run_pass(1'b0, dc, nw, mr, dcv, da);
        checks++; if (exp_val_q.size() != 0) begin errors++; $display("FAIL round_trip_sb_left: got %0d want 0", exp_val_q.size()); end
    endtask

    task automatic test_timing();
        int dc, nw, mr;
        logic [6:0] dcv;
        logic da;
        flush_sb();
        load_random();
        run_pass(1'b0, dc, nw, mr, dcv, da);
        checks++; if (dc != 131) begin errors++; $display("FAIL timing_done_cycle: got %0d want 131", dc); end
        checks++; if (dcv !== 7'd64) begin errors++; $display("FAIL timing_done_cnt: got %0d want 64", dcv); end
        checks++; if (nw != 64) begin errors++; $display("FAIL timing_writes: got %0d want 64", nw); end
        checks++; if (mr != 1) begin errors++; $display("FAIL timing_write_width: got %0d want 1", mr); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL timing_done_width: got %b want 0", da); end
        checks++; if (exp_val_q.size() != 0) begin errors++; $display("FAIL timing_sb_left: got %0d want 0", exp_val_q.size()); end
    endtask

    task automatic test_busy_start();
        int dc, nw, mr;
        logic [6:0] dcv;
        logic da;
        flush_sb();
        load_random();
        run_pass(1'b1, dc, nw, mr, dcv, da);
        checks++; if (nw != 64) begin errors++; $display("FAIL busy_writes: got %0d want 64", nw); end
        checks++; if (dc != 131) begin errors++; $display("FAIL busy_done_cycle: got %0d want 131", dc); end
        checks++; if (exp_val_q.size() != 0) begin errors++; $display("FAIL busy_sb_left: got %0d want 0", exp_val_q.size()); end
    endtask

    task automatic test_midpass_reset();
        int dc, nw, mr;
        logic [6:0] dcv;
        logic da;
        bit found;
        found = 1'b0;
        flush_sb();
        load_random();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (read_enable && cnt_value == 7'd30) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL midpass_reach30: got found=%0d want 1", found); end
        // Reset lands mid-cycle, so the async path alone must clear the outputs.
        #1 rst = 1'b1;
        #1;
        checks++; if (read_enable !== 1'b0) begin errors++; $display("FAIL midrst_read_enable: got %b want 0", read_enable); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midrst_write_enable: got %b want 0", write_enable); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (cnt_value !== 7'd0) begin errors++; $display("FAIL midrst_cnt_value: got %0d want 0", cnt_value); end
        checks++; if (write_value !== 25'd0) begin errors++; $display("FAIL midrst_write_value: got %h want 0", write_value); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_enable !== 1'b0 || cnt_value !== 7'd0) begin
            errors++;
            $display("FAIL midrst_no_resume: got read_enable=%b cnt=%0d want 0 and 0", read_enable, cnt_value);
        end
        flush_sb();
        load_random();
        run_pass(1'b0, dc, nw, mr, dcv, da);
        checks++; if (dc != 131) begin errors++; $display("FAIL midrst_fresh_done: got %0d want 131", dc); end
        checks++; if (nw != 64) begin errors++; $display("FAIL midrst_fresh_writes: got %0d want 64", nw); end
        checks++; if (exp_val_q.size() != 0) begin errors++; $display("FAIL midrst_sb_left: got %0d want 0", exp_val_q.size()); end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) src_mem[k] = '0;
        test_reset();
        test_single_bit();
        test_round_trip();
        test_timing();
        test_busy_start();
        test_midpass_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
